// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall / branch flush controller for a 5-stage pipe; mem_wait freezes everything.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] id_rs,
  input  logic [5:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memrd,
  input  logic [5:0] ex_rd,
  input  logic       br_taken,
  input  logic       mem_wait,
  output logic       pc_wr,
  output logic       ifid_wr,
  output logic       ifid_flush,
  output logic       idex_bubble
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  localparam logic [1:0] LU_CNT = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FL_CNT = 2'(FLUSH_LEN - 1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       lu_hazard;

  assign lu_hazard = ex_memrd && (ex_rd != 6'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else if (br_taken) begin
      // A taken branch overrides any pending load-use stall.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_n = FLUSH;
        cnt_n   = FL_CNT;
      end else begin
        state_n = RUN;
        cnt_n   = 2'd0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (lu_hazard) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_n = LU_STALL;
              cnt_n   = LU_CNT;
            end
          end
        end
        LU_STALL: begin
          pc_wr       = 1'b0;
          ifid_wr     = 1'b0;
          idex_bubble = 1'b1;
          cnt_n       = cnt - 2'd1;
          if (cnt <= 2'd1) begin
            state_n = RUN;
            cnt_n   = 2'd0;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_n       = cnt - 2'd1;
          if (cnt <= 2'd1) begin
            state_n = RUN;
            cnt_n   = 2'd0;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else if (!mem_wait) begin
      if (idex_bubble && !ifid_flush) stall_cycles <= sat_inc(stall_cycles);
      if (br_taken)                   flush_events <= sat_inc(flush_events);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl, three parameterizations checked
// every cycle against a bubble/flush-countdown model; honours HAZ_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memrd, br_taken, mem_wait;
  wire  [3:0] oa, ob, oc;   // {pc_wr, ifid_wr, ifid_flush, idex_bubble}

  int tests = 0;
  int fails = 0;

  int ll_p[3] = '{1, 3, 2};
  int fl_p[3] = '{2, 2, 1};
  int m_stall[3] = '{0, 0, 0};
  int m_flush[3] = '{0, 0, 0};
  int n_stall[3], n_flush[3];
  int m_sc[3] = '{0, 0, 0};
  int m_fe[3] = '{0, 0, 0};

  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  wire [15:0] sa, fa, sb, fb, sc, fc;
`endif

  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd), .ex_rd(ex_rd), .br_taken(br_taken),
    .mem_wait(mem_wait), .pc_wr(oa[3]), .ifid_wr(oa[2]), .ifid_flush(oa[1]), .idex_bubble(oa[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sa), .flush_events(fa)
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_LEN(2)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd), .ex_rd(ex_rd), .br_taken(br_taken),
    .mem_wait(mem_wait), .pc_wr(ob[3]), .ifid_wr(ob[2]), .ifid_flush(ob[1]), .idex_bubble(ob[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sb), .flush_events(fb)
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(2), .FLUSH_LEN(1)) u_c (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd), .ex_rd(ex_rd), .br_taken(br_taken),
    .mem_wait(mem_wait), .pc_wr(oc[3]), .ifid_wr(oc[2]), .ifid_flush(oc[1]), .idex_bubble(oc[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sc), .flush_events(fc)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hazard();
    return ex_memrd && (ex_rd != 0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // Behavioural model: count of bubble cycles still owed and flush cycles still owed.
  function automatic void model(input int ll, input int fl, input int st, input int fs,
                                output logic [3:0] e, output int nst, output int nfs);
    nst = st;
    nfs = fs;
    if (rst) begin
      e = 4'b0011; nst = 0; nfs = 0;
    end else if (mem_wait) begin
      e = 4'b0000;
    end else if (br_taken) begin
      e = 4'b1111; nst = 0; nfs = fl - 1;
    end else if (fs > 0) begin
      e = 4'b1111; nfs = fs - 1;
    end else if (st > 0) begin
      e = 4'b0001; nst = st - 1;
    end else if (hazard()) begin
      e = 4'b0001; nst = ll - 1;
    end else begin
      e = 4'b1100;
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [3:0] e, got;
      logic [15:0] gs, gf;
      model(ll_p[k], fl_p[k], m_stall[k], m_flush[k], e, n_stall[k], n_flush[k]);
      got = (k == 0) ? oa : (k == 1) ? ob : oc;
      chk($sformatf("model_out_%0d", k), {12'd0, got}, {12'd0, e});
      if (rst) begin
        m_sc[k] = 0; m_fe[k] = 0;
      end
`ifdef HAZ_PERF_CNT_EN
      gs = (k == 0) ? sa : (k == 1) ? sb : sc;
      gf = (k == 0) ? fa : (k == 1) ? fb : fc;
      chk($sformatf("stall_cycles_%0d", k), gs, 16'(m_sc[k]));
      chk($sformatf("flush_events_%0d", k), gf, 16'(m_fe[k]));
`else
      gs = 16'd0; gf = 16'd0;
`endif
      if (!rst && !mem_wait) begin
        if (e[0] && !e[1] && m_sc[k] < 65535) m_sc[k]++;
        if (br_taken && m_fe[k] < 65535) m_fe[k]++;
      end
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      m_stall[j] <= n_stall[j];
      m_flush[j] <= n_flush[j];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_memrd = 0; ex_rd = 0; br_taken = 0; mem_wait = 0;
  endtask

  task automatic set_lu();
    idle();
    ex_memrd = 1; ex_rd = 6'd5; id_rs = 6'd5; id_uses_rs = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_a", {12'd0, oa}, 16'h3);
    chk("rst_b", {12'd0, ob}, 16'h3);
    nxt(); rst = 1'b0;
    @(negedge clk); chk("run_a", {12'd0, oa}, 16'hC);
    // load-use r5: A stalls once, B three times
    nxt(); set_lu();
    @(negedge clk); chk("lu1_a", {12'd0, oa}, 16'h1); chk("lu1_b", {12'd0, ob}, 16'h1);
    nxt(); idle();
    @(negedge clk); chk("lu2_a", {12'd0, oa}, 16'hC); chk("lu2_b", {12'd0, ob}, 16'h1);
    nxt(); @(negedge clk); chk("lu3_b", {12'd0, ob}, 16'h1);
    nxt(); @(negedge clk); chk("lu4_b", {12'd0, ob}, 16'hC);
    nxt(); ex_memrd = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    @(negedge clk); chk("rd0_a", {12'd0, oa}, 16'hC); chk("rd0_b", {12'd0, ob}, 16'hC);
    // single-cycle branch
    nxt(); idle(); br_taken = 1;
    @(negedge clk); chk("br1_a", {12'd0, oa}, 16'hF); chk("br1_c", {12'd0, oc}, 16'hF);
    nxt(); br_taken = 0;
    @(negedge clk); chk("br2_a", {12'd0, oa}, 16'hF); chk("br2_c", {12'd0, oc}, 16'hC);
    nxt(); @(negedge clk); chk("br3_a", {12'd0, oa}, 16'hC);
    // branch during B's second stall cycle
    nxt(); set_lu();
    @(negedge clk); chk("bs1_b", {12'd0, ob}, 16'h1);
    nxt(); idle(); br_taken = 1;
    @(negedge clk); chk("bs2_b", {12'd0, ob}, 16'hF);
    nxt(); br_taken = 0;
    @(negedge clk); chk("bs3_b", {12'd0, ob}, 16'hF);
    nxt(); @(negedge clk); chk("bs4_b", {12'd0, ob}, 16'hC);
    // mem_wait frozen mid-flush
    nxt(); br_taken = 1;
    @(negedge clk); chk("mw0_a", {12'd0, oa}, 16'hF);
    for (int i = 0; i < 4; i++) begin
      nxt(); br_taken = 0; mem_wait = 1;
      @(negedge clk); chk("mw_hold_a", {12'd0, oa}, 16'h0);
    end
    nxt(); mem_wait = 0;
    @(negedge clk); chk("mw_fin_a", {12'd0, oa}, 16'hF);
    nxt(); @(negedge clk); chk("mw_run_a", {12'd0, oa}, 16'hC);
    // reset during B's stall
    nxt(); set_lu();
    @(negedge clk); chk("rs1_b", {12'd0, ob}, 16'h1);
    nxt(); idle();
    @(negedge clk); chk("rs2_b", {12'd0, ob}, 16'h1);
    nxt(); rst = 1'b1;
    @(negedge clk); chk("rs3_b", {12'd0, ob}, 16'h3);
`ifdef HAZ_PERF_CNT_EN
    chk("rs_cnt_b", sb, 16'd0);
    chk("rs_fe_b", fb, 16'd0);
`endif
    nxt(); rst = 1'b0;
    @(negedge clk); chk("rs4_b", {12'd0, ob}, 16'hC);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst        = ($urandom_range(0, 149) == 0);
      mem_wait   = ($urandom_range(0, 5) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      ex_memrd   = 1'($urandom_range(0, 1));
      ex_rd      = 6'($urandom_range(0, 3));
      id_rs      = 6'($urandom_range(0, 3));
      id_rt      = 6'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
    end
    nxt(); rst = 1'b0; idle();
    repeat (5) nxt();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, rst is the reset.
REQ-002 Parameter LOAD_LAT SHALL default to 1 and set the load-use bubble count (legal range 1-3).
REQ-003 Parameter FLUSH_LEN SHALL default to 2 and set the cycles squashed after a taken branch or jump (legal range 1-3).
REQ-004 clk  in  1  pipeline clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 id_rs, id_rt  in  6 each  source register numbers of the instruction in ID.
REQ-007 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 ex_memrd  in  1  instruction in EX is a load (ID/EX buffer memrd output).
REQ-009 ex_rd  in  6  destination register of the instruction in EX.
REQ-010 br_taken  in  1  branch or jump resolved taken this cycle.
REQ-011 mem_wait  in  1  data memory not ready; whole pipe freezes.
REQ-012 pc_wr  out  1  PC load enable.
REQ-013 ifid_wr  out  1  IF/ID buffer load enable.
REQ-014 ifid_flush  out  1  IF/ID buffer loads a NOP.
REQ-015 idex_bubble  out  1  forces every ID/EX control input (regwrt, branch, btype, jump, memtoreg, memrd, memwrt, aluop, alusrc1/0) to 0.

Function
REQ-016 FSM states SHALL be RUN, LU_STALL and FLUSH, with a 2-bit down-counter cnt.
REQ-017 Outputs SHALL be combinational from state, cnt and current inputs, so stalls and flushes take effect in the detecting cycle.
REQ-018 A load-use hazard SHALL be detected when ex_memrd=1, ex_rd!=0, and either (id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd).
REQ-019 Priority SHALL be: rst > mem_wait > br_taken > load-use > normal.
REQ-020 When mem_wait=1, the block SHALL drive pc_wr=0, ifid_wr=0, ifid_flush=0 and idex_bubble=0, and state and cnt SHALL hold.
REQ-021 br_taken SHALL be ignored while mem_wait=1; its source holds br_taken until mem_wait deasserts.
REQ-022 RUN with no event SHALL drive pc_wr=1, ifid_wr=1, ifid_flush=0, idex_bubble=0.
REQ-023 br_taken in any state SHALL drive pc_wr=1, ifid_flush=1, idex_bubble=1 that cycle.
REQ-024 After br_taken, the next state SHALL be FLUSH with cnt=FLUSH_LEN-1 when FLUSH_LEN>1, otherwise RUN; a pending LU_STALL SHALL be abandoned.
REQ-025 FLUSH SHALL drive pc_wr=1, ifid_flush=1, idex_bubble=1 and decrement cnt, moving to RUN after the cycle in which cnt==1.
REQ-026 A load-use in RUN SHALL drive pc_wr=0, ifid_wr=0, idex_bubble=1 that cycle.
REQ-027 After a load-use in RUN, the next state SHALL be LU_STALL with cnt=LOAD_LAT-1 when LOAD_LAT>1, otherwise RUN.
REQ-028 LU_STALL SHALL drive pc_wr=0, ifid_wr=0, idex_bubble=1 and decrement cnt, moving to RUN after the cycle in which cnt==1; hazard detection SHALL not reload cnt in this state.
REQ-029 A new load-use detected in the first RUN cycle after a stall SHALL start a fresh stall with no gap cycle.

Reset
REQ-030 While rst=1, outputs SHALL be pc_wr=0, ifid_wr=0, ifid_flush=1, idex_bubble=1.
REQ-031 While rst=1, state SHALL be RUN, cnt=0, and both performance counters (when present) SHALL be 0.
REQ-032 A reset asserted mid-stall or mid-flush SHALL abort it immediately; the first cycle after deassertion SHALL behave as RUN.

Configuration
REQ-033 Macro HAZ_PERF_CNT_EN SHALL add outputs stall_cycles[15:0] (cycles with idex_bubble=1 and ifid_flush=0) and flush_events[15:0] (count of accepted br_taken).
REQ-034 With HAZ_PERF_CNT_EN defined, both counters SHALL saturate at 16'hFFFF and SHALL not count while mem_wait=1.
REQ-035 Without HAZ_PERF_CNT_EN, the ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Load r5 in EX, ID reads rs=5, LOAD_LAT=1 -> one cycle of pc_wr=0, ifid_wr=0, idex_bubble=1, then RUN outputs.
REQ-037 Same stimulus with LOAD_LAT=3 -> exactly 3 bubble cycles; ex_rd=0 gives no stall.
REQ-038 br_taken one cycle, FLUSH_LEN=2 -> ifid_flush=1 and idex_bubble=1 for 2 cycles with pc_wr=1, then RUN.
REQ-039 br_taken in the second LU_STALL cycle (LOAD_LAT=3) -> stall aborted, 2-cycle flush follows.
REQ-040 mem_wait held 4 cycles mid-FLUSH -> all enables 0 for 4 cycles, then the remaining flush cycle completes.
REQ-041 rst pulsed during LU_STALL -> reset output values immediately; RUN outputs in the first cycle after release; counters read 0.
